sseg_scan_ctrl: RTL and testbench
=================================

# sseg_scan_ctrl

Scan scheduler for the 3-digit, common-anode seven-segment display. It time-shares the segment bus between the three digits, with a fixed dwell per digit. It inserts an all-off blanking gap before each digit to suppress ghosting, and applies PWM brightness inside each dwell. New digit patterns are taken through a valid/ready handshake only at frame boundaries, so a frame is never torn. Sits between the display-content logic (BCD/hex encoders) and the board `an`/`sseg` pins.

## Interface
- `DWELL_CYCLES`, 16384: clocks per digit SHOW phase; must be a multiple of 16, ≥16.
- `BLANK_CYCLES`, 256: clocks per digit BLANK phase; ≥1.
- `BLINK_FRAMES`, 64: frames per blink half-period (only used with `SSEG_SCAN_BLINK_EN`).
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-low reset.
- `upd_valid` in 1: new content offered.
- `upd_ready` out 1: content accepted this cycle when `upd_valid` is also high.
- `upd_d2`, `upd_d1`, `upd_d0` in 8 each: active-low segment patterns, bit 7 = dp.
- `upd_bright` in 4: brightness, 0 = 1/16 duty, 15 = full.
- `upd_blink` in 3: per-digit blink mask (port exists only with `SSEG_SCAN_BLINK_EN`).
- `an` out 3: active-low digit enables, bit i = digit i.
- `sseg` out 8: active-low segments.
- `frame_done` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- FSM states: BLANK, SHOW; digit index `dig` ∈ {0,1,2}; shared down-counter `cnt`.
- BLANK(dig): lasts BLANK_CYCLES; `an`=3'b111, `sseg`=8'hFF. Then go to SHOW(dig).
- SHOW(dig): lasts DWELL_CYCLES; `sseg`=shadow pattern of `dig`. Then go to BLANK(dig+1); after dig 2, go to BLANK(0).
- PWM in SHOW: elapsed count e = 0..DWELL_CYCLES−1. The digit is lit (`an` bit `dig` low, others high) while e < (bright+1)·(DWELL_CYCLES/16); otherwise `an`=3'b111. `sseg` holds the pattern for the whole dwell.
- Shadow registers: d2, d1, d0, bright, and blink mask. Display reads only the shadows.
- Handshake: `upd_ready`=1 exactly on the last cycle of SHOW(2), coincident with `frame_done`. If `upd_valid` is 1 that cycle, all upd_* are latched into the shadows and take effect from BLANK(0). Otherwise the shadows hold.
- Producer may hold `upd_valid` indefinitely; it is accepted at the next frame end. Data need only be stable in the accept cycle.
- Reset shadows: patterns 8'hFF, bright 4'hF, blink 3'b000.
- Reset mid-frame: everything returns asynchronously to the reset state. Any pending update is lost.

## Timing
- Reset values: `an`=3'b111, `sseg`=8'hFF, `upd_ready`=0, `frame_done`=0. State is BLANK(0) with `cnt` loaded for BLANK_CYCLES.
- `an`, `sseg`, `frame_done` are registered; `upd_ready` is decoded from registered state, with no combinational path from `upd_valid`.
- First lit cycle after reset release: clock BLANK_CYCLES+1 (first SHOW(0) cycle).
- Frame period: 3·(BLANK_CYCLES+DWELL_CYCLES) clocks; with defaults, 49920 clocks (~1.0 kHz).
- Update latency: an accepted update appears on `sseg` in the first SHOW(0) cycle, i.e. BLANK_CYCLES+1 clocks after acceptance.
- Width: `cnt` is clog2(max(DWELL_CYCLES, BLANK_CYCLES)) bits. The PWM threshold is (bright+1)·(DWELL_CYCLES>>4), computed without overflow (width of `cnt`+1).

## Configuration
- `SSEG_SCAN_BLINK_EN` defined:
  - `upd_blink` port and a frame counter are present.
  - A blink phase toggles every BLINK_FRAMES frames; the phase resets to "on".
  - During the "off" phase, digits with their shadow blink bit set keep `an` high for their whole SHOW.
- Not defined: no `upd_blink` port, no frame counter; behaviour is identical to blink mask 0.

## Structure
- Package `sseg_pkg`: NUM_DIGITS=3, SSEG_BLANK=8'hFF, AN_OFF=3'b111, state encoding localparams for BLANK/SHOW.
- Sub-module `sseg_dwell_timer`: loadable down-counter with `load`, `load_val`, `done` (count==0), and `elapsed` output for the PWM compare. The FSM, shadows and handshake stay in `sseg_scan_ctrl`.

## Test plan
- Reset, then run 1 frame with DWELL=32, BLANK=4 → `an` sequence is 111×4, 110×32, 111×4, 101×32, 111×4, 011×32; `sseg`=FF throughout; `frame_done` pulses at clock 108.
- `upd_valid`=1 with d0=8'hC0, d1=8'hF9, d2=8'hA4, bright=15, raised mid-frame → `upd_ready`/accept only on the frame-end cycle; next frame shows C0, F9, A4 on digits 0, 1, 2.
- bright=3, DWELL=32 → each digit lit for exactly 8 of 32 SHOW cycles; bright=0 → 2 cycles.
- New data presented, then withdrawn before the frame end → not accepted; shadows unchanged.
- Reset asserted mid-SHOW(1) → `an`=111 and `sseg`=FF immediately (asynchronous); after release, the display restarts at BLANK(0) with blank shadows.
- With `SSEG_SCAN_BLINK_EN`, BLINK_FRAMES=2, blink=3'b010 → digit 1 is dark in frames 2–3 and lit in frames 0–1 and 4–5; digits 0 and 2 are always lit.

Source files
------------

// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg_pkg
// Purpose  : Shared constants, scan state encoding and a digit-enable helper
//            for the seven-segment scan controller.
// Contents : NUM_DIGITS  - digits on the display
//            SSEG_BLANK  - all segments off (active-low)
//            AN_OFF      - all digit enables off (active-low)
//            scan_state_t- BLANK / SHOW phase of a digit slot
//            an_select() - active-low one-cold enable for a digit index
// Revision : 1.0 - initial release
// ============================================================================
package sseg_pkg;

  localparam int         NUM_DIGITS = 3;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [2:0] AN_OFF     = 3'b111;

  localparam logic [0:0] ST_BLANK_ENC = 1'b0;
  localparam logic [0:0] ST_SHOW_ENC  = 1'b1;

  typedef enum logic [0:0] {
    ST_BLANK = ST_BLANK_ENC,
    ST_SHOW  = ST_SHOW_ENC
  } scan_state_t;

  // Enable pattern that lights only digit `dig`; indices outside the display
  // fall out of the 3-bit vector and leave every digit dark.
  function automatic logic [2:0] an_select(input logic [1:0] dig);
    an_select = AN_OFF & ~(3'b001 << dig);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : sseg_dwell_timer
// Purpose  : Loadable down-counter timing one BLANK or SHOW phase. It also
//            reports how many cycles have elapsed since the last load, which
//            the scan controller compares against the PWM threshold.
// Ports    : clk      - system clock
//            reset    - asynchronous active-low reset
//            load     - reload the counter with load_val this cycle
//            load_val - phase length minus one
//            done     - counter has reached zero (last cycle of the phase)
//            elapsed  - cycles since the last load (0 on the first cycle)
// Revision : 1.0 - initial release
// ============================================================================
module sseg_dwell_timer #(
  parameter int           W         = 14,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done,
  output logic [W-1:0] elapsed
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;
  // Value the counter started from; elapsed = start - remaining.
  logic [W-1:0] top;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= RESET_VAL;
      top <= RESET_VAL;
    end else if (load) begin
      cnt <= load_val;
      top <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign done    = (cnt == '0);
  assign elapsed = top - cnt;

endmodule
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_ctrl
// Purpose  : Scan scheduler for a 3-digit common-anode seven-segment display.
//            Each digit slot is a BLANK gap (all off) followed by a SHOW
//            dwell with PWM brightness. New content is accepted through a
//            valid/ready handshake only on the last cycle of a frame, so a
//            frame is never torn.
// Ports    : clk          - system clock
//            reset        - asynchronous active-low reset
//            upd_valid    - producer offers new content
//            upd_ready    - high on the frame-end cycle; accept when valid
//            upd_d2/d1/d0 - active-low segment patterns, bit 7 = dp
//            upd_bright   - brightness, 0 = 1/16 duty, 15 = full
//            upd_blink    - per-digit blink mask (SSEG_SCAN_BLINK_EN only)
//            an           - active-low digit enables, bit i = digit i
//            sseg         - active-low segments
//            frame_done   - one-cycle pulse on the last cycle of each frame
// Options  : SSEG_SCAN_BLINK_EN - adds upd_blink and a frame-counted blink
//            phase; without it the design behaves as if the mask were 0.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DWELL_CYCLES = 16384,
  parameter int BLANK_CYCLES = 256,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [7:0] upd_d2,
  input  logic [7:0] upd_d1,
  input  logic [7:0] upd_d0,
  input  logic [3:0] upd_bright,
`ifdef SSEG_SCAN_BLINK_EN
  input  logic [2:0] upd_blink,
`endif
  output logic [2:0] an,
  output logic [7:0] sseg,
  output logic       frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] DWELL_LOAD  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_PENULT = CW'(DWELL_CYCLES - 2);
  localparam logic [CW:0]   PWM_STEP    = (CW + 1)'(DWELL_CYCLES / 16);
  localparam logic [1:0]    LAST_DIG    = 2'(NUM_DIGITS - 1);

  if ((DWELL_CYCLES < 16) || ((DWELL_CYCLES % 16) != 0) ||
      (BLANK_CYCLES < 1) || (BLINK_FRAMES < 1)) begin : g_bad_params
    $error("sseg_scan_ctrl: invalid timing parameters");
  end

  // --------------------------------------------------------------------------
  // State, timer and shadows
  // --------------------------------------------------------------------------
  scan_state_t   state, state_nx;
  logic [1:0]    dig, dig_nx;
  logic          done;
  logic [CW-1:0] elapsed;
  logic [CW-1:0] load_val;

  logic [7:0]    sh_d0, sh_d1, sh_d2;
  logic [3:0]    sh_bright;
  logic [2:0]    sh_blink;
  logic          blink_off;
  logic          accept;

  // The timer reloads on the last cycle of every phase; the new length is
  // that of the phase being entered.
  assign load_val = (state == ST_BLANK) ? DWELL_LOAD : BLANK_LOAD;

  sseg_dwell_timer #(
    .W         (CW),
    .RESET_VAL (BLANK_LOAD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (done),
    .load_val (load_val),
    .done     (done),
    .elapsed  (elapsed)
  );

  // Frame end is the final cycle of SHOW on the last digit.
  assign upd_ready = (state == ST_SHOW) && (dig == LAST_DIG) && done;
  assign accept    = upd_ready && upd_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_d0     <= SSEG_BLANK;
      sh_d1     <= SSEG_BLANK;
      sh_d2     <= SSEG_BLANK;
      sh_bright <= 4'hF;
    end else if (accept) begin
      sh_d0     <= upd_d0;
      sh_d1     <= upd_d1;
      sh_d2     <= upd_d2;
      sh_bright <= upd_bright;
    end
  end

`ifdef SSEG_SCAN_BLINK_EN
  localparam int             FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0]  FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_blink <= 3'b000;
    end else if (accept) begin
      sh_blink <= upd_blink;
    end
  end

  // Blink phase flips after every BLINK_FRAMES completed frames; it changes
  // on the frame boundary, so a frame never mixes phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (upd_ready) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end
`else
  assign sh_blink  = 3'b000;
  assign blink_off = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_BLANK;
      dig   <= 2'd0;
    end else begin
      state <= state_nx;
      dig   <= dig_nx;
    end
  end

  // Outputs are registered but computed from the next state, so the pins
  // line up with the state they describe rather than lagging a cycle.
  logic [CW:0] pwm_thr;
  logic [CW:0] e_nx;
  logic [7:0]  pat_nx;
  logic        blink_bit_nx;
  logic [2:0]  an_nx;
  logic [7:0]  sseg_nx;
  logic        frame_done_nx;

  assign pwm_thr = ((CW + 1)'(sh_bright) + (CW + 1)'(1)) * PWM_STEP;

  always_comb begin
    state_nx      = state;
    dig_nx        = dig;
    e_nx          = '0;
    pat_nx        = SSEG_BLANK;
    blink_bit_nx  = 1'b0;
    an_nx         = AN_OFF;
    sseg_nx       = SSEG_BLANK;
    frame_done_nx = 1'b0;

    case (state)
      ST_BLANK: begin
        if (done) begin
          state_nx = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (done) begin
          state_nx = ST_BLANK;
          dig_nx   = (dig == LAST_DIG) ? 2'd0 : dig + 2'd1;
        end
        // One cycle before the frame-end cycle, so the registered pulse
        // coincides with upd_ready.
        frame_done_nx = (dig == LAST_DIG) && (elapsed == SHOW_PENULT);
      end
      default: begin
        state_nx = ST_BLANK;
        dig_nx   = 2'd0;
      end
    endcase

    case (dig_nx)
      2'd0:    begin pat_nx = sh_d0; blink_bit_nx = sh_blink[0]; end
      2'd1:    begin pat_nx = sh_d1; blink_bit_nx = sh_blink[1]; end
      default: begin pat_nx = sh_d2; blink_bit_nx = sh_blink[2]; end
    endcase

    if (state_nx == ST_SHOW) begin
      sseg_nx = pat_nx;
      // Entering SHOW starts the dwell at elapsed 0.
      e_nx = (state == ST_BLANK) ? '0 : ({1'b0, elapsed} + (CW + 1)'(1));
      if ((e_nx < pwm_thr) && !(blink_off && blink_bit_nx)) begin
        an_nx = an_select(dig_nx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an         <= AN_OFF;
      sseg       <= SSEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nx;
      sseg       <= sseg_nx;
      frame_done <= frame_done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_ctrl
// Purpose  : Self-checking bench for sseg_scan_ctrl with short timing
//            (DWELL 32, BLANK 4, BLINK_FRAMES 2). Expected pins are derived
//            from the cycle position within the frame and a model of the
//            shadow contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

  localparam int DW    = 32;
  localparam int BL    = 4;
  localparam int BF    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = 3 * SLOT;
  localparam int NPLAN = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       upd_valid = 1'b0;
  logic [7:0] upd_d2 = 8'h00, upd_d1 = 8'h00, upd_d0 = 8'h00;
  logic [3:0] upd_bright = 4'h0;
  logic [2:0] upd_blink = 3'b000;
  logic       upd_ready;
  logic [2:0] an;
  logic [7:0] sseg;
  logic       frame_done;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_d2     (upd_d2),
    .upd_d1     (upd_d1),
    .upd_d0     (upd_d0),
    .upd_bright (upd_bright),
`ifdef SSEG_SCAN_BLINK_EN
    .upd_blink  (upd_blink),
`endif
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int n      = 0;   // cycles since reset release
  int base   = 0;   // plan index offset

  logic [7:0] m_d [3];
  logic [3:0] m_b;
  logic [2:0] m_blink;
  int         lit_cnt [3];

  int         offer_pos    [NPLAN];
  int         withdraw_pos [NPLAN];
  logic [3:0] plan_br      [NPLAN];
  bit         plan_dir     [NPLAN];
  bit         plan_jit     [NPLAN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_d[k]     = 8'hFF;
      lit_cnt[k] = 0;
    end
    m_b     = 4'hF;
    m_blink = 3'b000;
  endtask

  function automatic bit blinked(input int nn, input int slot);
`ifdef SSEG_SCAN_BLINK_EN
    return ((((nn / FRAME) / BF) % 2) == 1) && (m_blink[slot] == 1'b1);
`else
    return (nn < 0) && (slot < 0);
`endif
  endfunction

  task automatic check_cycle();
    int pos, slot, w, lit_exp;
    logic [2:0] ea;
    logic [7:0] es;
    pos  = n % FRAME;
    slot = pos / SLOT;
    w    = pos % SLOT;
    ea   = 3'b111;
    es   = 8'hFF;
    if (w >= BL) begin
      es = m_d[slot];
      if (((w - BL) < (m_b + 1) * (DW / 16)) && !blinked(n, slot))
        ea = 3'b111 ^ (3'b001 << slot);
    end
    chk("an", {29'd0, an}, {29'd0, ea});
    chk("sseg", {24'd0, sseg}, {24'd0, es});
    chk("upd_ready", {31'd0, upd_ready}, {31'd0, (pos == FRAME - 1)});
    chk("frame_done", {31'd0, frame_done}, {31'd0, (pos == FRAME - 1)});
    for (int k = 0; k < 3; k++)
      if (an[k] === 1'b0) lit_cnt[k]++;
    if (pos == FRAME - 1) begin
      for (int k = 0; k < 3; k++) begin
        lit_exp = blinked(n, k) ? 0 : (m_b + 1) * (DW / 16);
        chk($sformatf("lit_cycles_d%0d", k), lit_cnt[k], lit_exp);
        lit_cnt[k] = 0;
      end
    end
  endtask

  task automatic rand_data();
    upd_d0    = 8'($urandom);
    upd_d1    = 8'($urandom);
    upd_d2    = 8'($urandom);
    upd_blink = 3'($urandom);
  endtask

  task automatic drive();
    int pos, f;
    pos = n % FRAME;
    f   = n / FRAME + base;
    if (pos == 0) upd_valid = 1'b0;
    if (f < NPLAN) begin
      if (pos == offer_pos[f]) begin
        upd_valid = 1'b1;
        rand_data();
        upd_bright = plan_br[f];
        if (plan_dir[f]) begin
          upd_d0 = 8'hC0; upd_d1 = 8'hF9; upd_d2 = 8'hA4; upd_blink = 3'b010;
        end
      end else if (upd_valid && plan_jit[f]) begin
        rand_data();
      end
      if (pos == withdraw_pos[f]) upd_valid = 1'b0;
    end
    // Sampled by the DUT at the next edge, in the frame-end cycle.
    if (upd_valid && (pos == FRAME - 1)) begin
      m_d[0] = upd_d0; m_d[1] = upd_d1; m_d[2] = upd_d2;
      m_b    = upd_bright;
`ifdef SSEG_SCAN_BLINK_EN
      m_blink = upd_blink;
`else
      m_blink = 3'b000;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    check_cycle();
    drive();
  endtask

  initial begin
    for (int i = 0; i < NPLAN; i++) begin
      offer_pos[i] = -1; withdraw_pos[i] = -1;
      plan_br[i] = 4'hF; plan_dir[i] = 1'b0; plan_jit[i] = 1'b0;
    end
    offer_pos[1] = 20;  plan_br[1] = 4'hF; plan_dir[1] = 1'b1;
    offer_pos[2] = 50;  plan_br[2] = 4'h3; plan_jit[2] = 1'b1;
    offer_pos[3] = 10;  plan_br[3] = 4'h0;
    offer_pos[4] = 30;  plan_br[4] = 4'h9; withdraw_pos[4] = 90;
    offer_pos[5] = int'($urandom_range(1, 106)); plan_br[5] = 4'($urandom_range(5, 15));
    offer_pos[8] = int'($urandom_range(1, 106)); plan_br[8] = 4'($urandom_range(0, 15));
    plan_jit[8]  = 1'b1;

    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", {29'd0, an}, 32'h7);
    chk("rst_sseg", {24'd0, sseg}, 32'hFF);
    chk("rst_upd_ready", {31'd0, upd_ready}, 32'h0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    n = 0;
    check_cycle();
    drive();
    while (n < 6 * FRAME + SLOT + 14) tick();

    // Asynchronous reset in the middle of SHOW(1).
    upd_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_an", {29'd0, an}, 32'h7);
    chk("midrst_sseg", {24'd0, sseg}, 32'hFF);
    chk("midrst_upd_ready", {31'd0, upd_ready}, 32'h0);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    n = 0;
    base = 7;
    model_reset();
    check_cycle();
    drive();
    repeat (3 * FRAME) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
